xcom_cmd_fifo: RTL and testbench
================================

XCOM_CMD_FIFO -- requirements
Module: xcom_cmd_fifo

Command queue between tProcessor and the XCOM core command port: buffers tProc XCOM commands and issues them one at a time when the core reports ready.

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queued commands; legal values are powers of 2 from 2 to 64.
REQ-002 SHALL have parameter HOLD, default 4, cycles waited after an issue before qp_rdy_i is sampled again; legal values are 1 to 15.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all logic is in the c_clk domain.
REQ-004 c_clk  in  1  command/tProc clock.
REQ-005 c_rst_i  in  1  synchronous active-high reset.
REQ-006 cmd_en_i  in  1  push request, one command per high cycle.
REQ-007 cmd_op_i  in  5  XCOM opcode (0 clr flag ... 19 wr mem).
REQ-008 cmd_dt1_i  in  32  data/address word 1.
REQ-009 cmd_dt2_i  in  32  data word 2.
REQ-010 ovf_clr_i  in  1  clears the sticky overflow flag.
REQ-011 qp_rdy_i  in  1  XCOM core ready to accept a command.
REQ-012 qp_en_o  out  1  one-cycle command strobe to the XCOM core.
REQ-013 qp_op_o  out  5  issued opcode.
REQ-014 qp_dt1_o  out  32  issued word 1.
REQ-015 qp_dt2_o  out  32  issued word 2.
REQ-016 cmd_full_o  out  1  queue holds DEPTH entries.
REQ-017 cmd_empty_o  out  1  queue holds 0 entries.
REQ-018 cmd_cnt_o  out  log2(DEPTH)+1  current occupancy.
REQ-019 cmd_ovf_o  out  1  sticky flag, set when a push is dropped.
REQ-020 busy_o  out  1  high when the FSM is not in IDLE or the queue is non-empty.

Function
REQ-021 SHALL store {op, dt1, dt2} (69 bits) per entry in a circular buffer with read/write pointers that wrap modulo DEPTH.
REQ-022 Push: cmd_en_i=1 and cmd_full_o=0 at edge N; entry written and cmd_cnt_o incremented, visible at N+1.
REQ-023 Push with cmd_full_o=1 SHALL be dropped, leaving contents and pointers unchanged, and SHALL set cmd_ovf_o at the next edge; this holds even if a pop occurs in the same cycle.
REQ-024 cmd_ovf_o SHALL clear on ovf_clr_i=1; when set and clear coincide, set wins.
REQ-025 FSM states are IDLE, ISSUE and HOLD.
REQ-026 IDLE -> ISSUE when cmd_empty_o=0 and qp_rdy_i=1; otherwise remain in IDLE.
REQ-027 ISSUE lasts exactly one cycle: qp_en_o=1, qp_op/dt1/dt2_o = head entry, head popped (count decremented at the end of the cycle); then -> HOLD.
REQ-028 HOLD lasts exactly HOLD cycles (4-bit counter), ignores qp_rdy_i, then -> IDLE.
REQ-029 Minimum latency: push at edge N into an empty queue with qp_rdy_i=1 gives qp_en_o=1 during cycle N+2.
REQ-030 Minimum issue spacing SHALL be HOLD+2 cycles, i.e. 6 at default.
REQ-031 qp_en_o SHALL be registered and never high for two consecutive cycles.
REQ-032 qp_op/dt1/dt2_o SHALL be registered and held stable from ISSUE until the next ISSUE.
REQ-033 Simultaneous push and pop SHALL leave cmd_cnt_o unchanged, with both operations performed.
REQ-034 Commands SHALL issue in strict FIFO order, never reordered, never duplicated.
REQ-035 cmd_cnt_o SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-036 c_rst_i=1 at an edge SHALL return the FSM to IDLE, zero pointers, cmd_cnt_o, the HOLD counter, qp_en_o, qp_op/dt1/dt2_o and cmd_ovf_o, and set cmd_empty_o=1 and cmd_full_o=0.
REQ-037 Reset mid-HOLD or mid-ISSUE SHALL discard all queued commands; no qp_en_o pulse occurs in the cycle after reset.

Verification
REQ-038 Single command: push op=2, dt1=1, dt2=0xFFFFFFFF into an empty queue with qp_rdy_i=1 -> qp_en_o pulses once at N+2 with those values; cmd_cnt_o goes 0, 1, 0.
REQ-039 Back-pressure: qp_rdy_i=0, push ops 1,0,2 -> no qp_en_o; raise qp_rdy_i -> three strobes in order 1,0,2, spaced 6 cycles apart.
REQ-040 Overflow: qp_rdy_i=0, DEPTH=8, push 9 commands -> cmd_full_o=1, cmd_cnt_o=8, cmd_ovf_o=1, 9th dropped; ovf_clr_i pulse -> cmd_ovf_o=0.
REQ-041 Full with pop: full queue, pop and push in the same cycle -> push dropped, cmd_ovf_o=1, cmd_cnt_o=7.
REQ-042 Wrap-around: 20 commands with dt1=0..19 streamed at a 1-in-3 push rate, qp_rdy_i=1 -> all 20 issued in order, cmd_ovf_o=0.
REQ-043 Reset mid-operation: assert c_rst_i during HOLD with 3 queued -> cmd_cnt_o=0, qp_en_o stays 0, all outputs at reset values.

Source files
------------

// File: rtl/xcom_cmd_fifo.sv
// rtl/xcom_cmd_fifo.sv - tProc-to-XCOM command queue
// Buffers {op, dt1, dt2} commands and issues one per ready window, then holds off HOLD cycles.
module xcom_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int HOLD  = 4
) (
  input  logic                     c_clk,
  input  logic                     c_rst_i,
  input  logic                     cmd_en_i,
  input  logic [4:0]               cmd_op_i,
  input  logic [31:0]              cmd_dt1_i,
  input  logic [31:0]              cmd_dt2_i,
  input  logic                     ovf_clr_i,
  input  logic                     qp_rdy_i,
  output logic                     qp_en_o,
  output logic [4:0]               qp_op_o,
  output logic [31:0]              qp_dt1_o,
  output logic [31:0]              qp_dt2_o,
  output logic                     cmd_full_o,
  output logic                     cmd_empty_o,
  output logic [$clog2(DEPTH):0]   cmd_cnt_o,
  output logic                     cmd_ovf_o,
  output logic                     busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      hold_q, hold_d;
  logic            qp_en_q, qp_en_d;
  logic [4:0]      qp_op_q, qp_op_d;
  logic [31:0]     qp_dt1_q, qp_dt1_d;
  logic [31:0]     qp_dt2_q, qp_dt2_d;
  logic            ovf_q, ovf_d;
  logic [68:0]     mem_q [DEPTH];

  logic full, empty, push_ok, pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = cmd_en_i & ~full;
  // The head is popped at the end of the strobe cycle; it was latched on entry.
  assign pop     = (state_q == ST_ISSUE);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    qp_en_d  = 1'b0;
    qp_op_d  = qp_op_q;
    qp_dt1_d = qp_dt1_q;
    qp_dt2_d = qp_dt2_q;
    ovf_d    = ovf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // A dropped push outranks a same-cycle clear.
    if (cmd_en_i && full)  ovf_d = 1'b1;
    else if (ovf_clr_i)    ovf_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty && qp_rdy_i) begin
          state_d = ST_ISSUE;
          qp_en_d = 1'b1;
          {qp_op_d, qp_dt1_d, qp_dt2_d} = mem_q[rd_ptr_q];
        end
      end
      ST_ISSUE: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
      ST_HOLD: begin
        if (hold_q == 4'(HOLD - 1)) state_d = ST_IDLE;
        else                        hold_d  = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (c_rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      qp_en_q  <= 1'b0;
      qp_op_q  <= '0;
      qp_dt1_q <= '0;
      qp_dt2_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      qp_en_q  <= qp_en_d;
      qp_op_q  <= qp_op_d;
      qp_dt1_q <= qp_dt1_d;
      qp_dt2_q <= qp_dt2_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge c_clk) begin
    if (!c_rst_i && push_ok) mem_q[wr_ptr_q] <= {cmd_op_i, cmd_dt1_i, cmd_dt2_i};
  end

  assign qp_en_o     = qp_en_q;
  assign qp_op_o     = qp_op_q;
  assign qp_dt1_o    = qp_dt1_q;
  assign qp_dt2_o    = qp_dt2_q;
  assign cmd_full_o  = full;
  assign cmd_empty_o = empty;
  assign cmd_cnt_o   = cnt_q;
  assign cmd_ovf_o   = ovf_q;
  assign busy_o      = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_xcom_cmd_fifo.sv
// tb/tb_xcom_cmd_fifo.sv - directed scoreboard bench for xcom_cmd_fifo
module tb_xcom_cmd_fifo;

  logic        c_clk = 1'b0;
  logic        c_rst_i, cmd_en_i, ovf_clr_i, qp_rdy_i;
  logic [4:0]  cmd_op_i;
  logic [31:0] cmd_dt1_i, cmd_dt2_i;
  logic        qp_en_o, cmd_full_o, cmd_empty_o, cmd_ovf_o, busy_o;
  logic [4:0]  qp_op_o;
  logic [31:0] qp_dt1_o, qp_dt2_o;
  logic [3:0]  cmd_cnt_o;

  xcom_cmd_fifo #(.DEPTH(8), .HOLD(4)) dut (
    .c_clk(c_clk), .c_rst_i(c_rst_i), .cmd_en_i(cmd_en_i), .cmd_op_i(cmd_op_i),
    .cmd_dt1_i(cmd_dt1_i), .cmd_dt2_i(cmd_dt2_i), .ovf_clr_i(ovf_clr_i),
    .qp_rdy_i(qp_rdy_i), .qp_en_o(qp_en_o), .qp_op_o(qp_op_o),
    .qp_dt1_o(qp_dt1_o), .qp_dt2_o(qp_dt2_o), .cmd_full_o(cmd_full_o),
    .cmd_empty_o(cmd_empty_o), .cmd_cnt_o(cmd_cnt_o), .cmd_ovf_o(cmd_ovf_o),
    .busy_o(busy_o)
  );

  always #5 c_clk = ~c_clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_issued = 0;
  logic        prev_en  = 1'b0;
  logic [68:0] sb [$];
  int          issue_times [$];

  always @(posedge c_clk) cyc++;

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue monitor: each strobe is matched against the head of the expected queue.
  always @(negedge c_clk) begin
    if (qp_en_o) begin
      n_issued++;
      issue_times.push_back(cyc);
      chk("no_back_to_back_strobe", prev_en, 1'b0);
      chk("sb_nonempty_at_issue", sb.size() != 0, 1'b1);
      if (sb.size() != 0) chk("issue_data", {qp_op_o, qp_dt1_o, qp_dt2_o}, sb.pop_front());
    end
    prev_en = qp_en_o;
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                      input bit expect_accept);
    cmd_en_i  = 1'b1;
    cmd_op_i  = op;
    cmd_dt1_i = d1;
    cmd_dt2_i = d2;
    if (expect_accept) sb.push_back({op, d1, d2});
    tick();
    cmd_en_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy_o && sb.size() == 0) break;
      tick();
    end
    chk(tag, {busy_o, sb.size() == 0}, 2'b01);
  endtask

  initial begin
    int base, k;
    c_rst_i = 1'b1; cmd_en_i = 1'b0; ovf_clr_i = 1'b0; qp_rdy_i = 1'b0;
    cmd_op_i = '0; cmd_dt1_i = '0; cmd_dt2_i = '0;
    tick(); tick();
    c_rst_i = 1'b0;
    tick();

    // Reset state
    chk("rst_cnt",   cmd_cnt_o,   4'd0);
    chk("rst_empty", cmd_empty_o, 1'b1);
    chk("rst_full",  cmd_full_o,  1'b0);
    chk("rst_ovf",   cmd_ovf_o,   1'b0);
    chk("rst_qp_en", qp_en_o,     1'b0);
    chk("rst_qp",    {qp_op_o, qp_dt1_o, qp_dt2_o}, 69'd0);
    chk("rst_busy",  busy_o,      1'b0);

    // Single command: strobe two edges after the push
    qp_rdy_i = 1'b1;
    push(5'd2, 32'd1, 32'hFFFF_FFFF, 1'b1);
    chk("single_cnt_after_push", cmd_cnt_o, 4'd1);
    chk("single_no_early_strobe", qp_en_o, 1'b0);
    tick();
    chk("single_strobe_latency", qp_en_o, 1'b1);
    chk("single_cnt_during_issue", cmd_cnt_o, 4'd1);
    tick();
    chk("single_strobe_width", qp_en_o, 1'b0);
    chk("single_cnt_after_pop", cmd_cnt_o, 4'd0);
    chk("single_qp_held", {qp_op_o, qp_dt1_o, qp_dt2_o}, {5'd2, 32'd1, 32'hFFFF_FFFF});
    wait_drain("single_drain", 50);

    // Back-pressure then release: order 1,0,2 at spacing 6
    qp_rdy_i = 1'b0;
    base = n_issued;
    push(5'd1, 32'h10, 32'h11, 1'b1);
    push(5'd0, 32'h20, 32'h21, 1'b1);
    push(5'd2, 32'h30, 32'h31, 1'b1);
    repeat (10) tick();
    chk("bp_no_issue", n_issued - base, 0);
    chk("bp_cnt", cmd_cnt_o, 4'd3);
    issue_times.delete();
    qp_rdy_i = 1'b1;
    wait_drain("bp_drain", 60);
    chk("bp_issue_count", issue_times.size(), 3);
    if (issue_times.size() == 3) begin
      chk("bp_gap0", issue_times[1] - issue_times[0], 6);
      chk("bp_gap1", issue_times[2] - issue_times[1], 6);
    end

    // Overflow: 9 pushes into an 8-deep queue
    qp_rdy_i = 1'b0;
    for (int i = 0; i < 9; i++) push(5'(i + 3), 32'(100 + i), 32'(200 + i), i < 8);
    chk("ovf_full", cmd_full_o, 1'b1);
    chk("ovf_cnt",  cmd_cnt_o,  4'd8);
    chk("ovf_set",  cmd_ovf_o,  1'b1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    chk("ovf_cleared", cmd_ovf_o, 1'b0);

    // Full with simultaneous pop: push still dropped
    qp_rdy_i = 1'b1;
    tick();
    chk("fullpop_issue", qp_en_o, 1'b1);
    push(5'd31, 32'hDEAD, 32'hBEEF, 1'b0);
    chk("fullpop_cnt", cmd_cnt_o, 4'd7);
    chk("fullpop_ovf", cmd_ovf_o, 1'b1);
    chk("fullpop_not_full", cmd_full_o, 1'b0);
    wait_drain("fullpop_drain", 200);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;

    // Wrap-around: 20 commands at a 1-in-3 rate, retrying while full
    base = n_issued;
    for (int i = 0; i < 20; i++) begin
      k = 0;
      while (cmd_full_o && k < 50) begin tick(); k++; end
      chk("wrap_full_wait", k < 50, 1'b1);
      push(5'(i % 20), 32'(i), ~32'(i), 1'b1);
      tick(); tick();
    end
    wait_drain("wrap_drain", 300);
    chk("wrap_issued", n_issued - base, 20);
    chk("wrap_ovf", cmd_ovf_o, 1'b0);
    chk("wrap_cnt", cmd_cnt_o, 4'd0);

    // Reset during HOLD with 3 queued
    qp_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) push(5'(7 + i), 32'(300 + i), 32'(400 + i), 1'b1);
    qp_rdy_i = 1'b1;
    k = 0;
    while (!qp_en_o && k < 10) begin tick(); k++; end
    chk("rsthold_issue_seen", qp_en_o, 1'b1);
    qp_rdy_i = 1'b0;
    tick();
    chk("rsthold_cnt_before", cmd_cnt_o, 4'd3);
    chk("rsthold_busy_before", busy_o, 1'b1);
    c_rst_i  = 1'b1;
    qp_rdy_i = 1'b1;
    tick();
    c_rst_i = 1'b0;
    sb.delete();
    base = n_issued;
    chk("rsthold_cnt",   cmd_cnt_o,   4'd0);
    chk("rsthold_empty", cmd_empty_o, 1'b1);
    chk("rsthold_full",  cmd_full_o,  1'b0);
    chk("rsthold_qp_en", qp_en_o,     1'b0);
    chk("rsthold_qp",    {qp_op_o, qp_dt1_o, qp_dt2_o}, 69'd0);
    chk("rsthold_ovf",   cmd_ovf_o,   1'b0);
    chk("rsthold_busy",  busy_o,      1'b0);
    repeat (12) tick();
    chk("rsthold_no_issue", n_issued - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
